stream_mac_accumulator: RTL
===========================

# stream_mac_accumulator

Multi-lane multiply-accumulate stage for the kernel-integrator RTL library: consumes an activation stream and a weight stream in lockstep, accumulates lane-wise products over a runtime-configurable block length, and emits one result beat per block. Sits between a weight/activation feeder and downstream output logic. Block length is programmed through a minimal AXI-lite write-only config port.

## Interface
- PE, 4: lanes per beat
- s_axis_input_WIDTH, 8: per-lane activation width
- s_axis_input_SIGNED, 0: 1 = activations two's complement
- weights_WIDTH, 8: per-lane weight width
- weights_SIGNED, 0: 1 = weights two's complement
- ACC0_WIDTH, 32: per-lane accumulator/output width, ≥ s_axis_input_WIDTH + weights_WIDTH
- BDIM_MAX, 1024: maximum block length (beats)
- BDIM_RESET, 16: block length after reset, 1..BDIM_MAX

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous, active-high reset
- s_axis_input_tdata  in  PE*s_axis_input_WIDTH  activations, lane i at [i*W +: W]
- s_axis_input_tvalid / s_axis_input_tready  in / out  1  activation handshake
- s_axis_weights_tdata  in  PE*weights_WIDTH  weights, same lane packing
- s_axis_weights_tvalid / s_axis_weights_tready  in / out  1  weight handshake
- m_axis_output_tdata  out  PE*ACC0_WIDTH  block results
- m_axis_output_tvalid / m_axis_output_tready  out / in  1  result handshake
- s_axilite_config_awaddr  in  4  write address
- s_axilite_config_awvalid / awready  in / out  1
- s_axilite_config_wdata  in  32  write data
- s_axilite_config_wvalid / wready  in / out  1
- s_axilite_config_bvalid / bready  out / in  1
- s_axilite_config_bresp  out  2  always 2'b00

## Operation
- Beat fires when both input and weight handshakes complete in the same cycle; tready of each stream = core_ready AND the other stream's tvalid. Never one without the other.
- Per lane: acc_i += in_i × w_i; operands sign- or zero-extended per *_SIGNED, product extended to ACC0_WIDTH, sum wraps modulo 2^ACC0_WIDTH (no saturation).
- First beat of a block: acc_i loaded with the product (no separate clear cycle); active length latched from pending length register.
- Beat counter counts 1..active_len; on final beat, acc+product written to output holding register, output full flag set, counter returns to 0.
- core_ready = NOT(next beat is final AND output full AND NOT m_axis_output_tready). Non-final beats of the next block proceed while output held.
- Output full cleared on m_axis_output_tvalid & tready; simultaneous clear and new final beat leaves full set with new data.
- Config FSM states: IDLE → RESP. IDLE: awready=wready=1 only when awvalid AND wvalid; on that cycle write decoded, go RESP. RESP: bvalid=1 until bready, then IDLE.
- awaddr[3:2]==0: pending length = wdata clamped (0→1, >BDIM_MAX→BDIM_MAX). Other addresses: no effect, bresp still OKAY.
- Pending length change never alters a block in progress; takes effect at next block's first beat.

## Timing
- Reset values: all tready 0 during reset cycle, m_axis_output_tvalid 0, tdata 0, awready/wready/bvalid 0, bresp 0, counter 0, pending length BDIM_RESET.
- Reset mid-block or with output held: partial sums and held result discarded; no output beat.
- Latency: m_axis_output_tvalid asserts the cycle after the final beat fires; tdata stable while tvalid && !tready.
- Throughput: one beat per cycle with tready held high; no bubble between blocks.
- Config write response: bvalid the cycle after aw/w accept.

## Test plan
- PE=4, len 4, activations all lanes = 1,2,3,4 per beat, weights 3, tready=1 → one output, every lane 30, tvalid 1 cycle after 4th beat.
- Output stalled 10 cycles after block 1 (len 4): block 2 beats 1–3 accepted, beat 4 tready=0 until output drained; block 1 tdata stable throughout.
- Signed both, ACC0_WIDTH 32, len 2, in −128, w 127 → each lane −32512 (0xFFFF8100).
- Unsigned, ACC0_WIDTH 16, len 2, in 255, w 255 → each lane 64514 (wrap of 130050).
- Write len 2 after 2 beats of a len-4 block → current block ends at beat 4, next at beat 2; write 0 → blocks of 1; write to addr 0x8 → length unchanged, bresp 0.
- Assert ap_rst after 3 beats of len-4 block → no output; post-reset len-16 block of 16 beats gives correct sum.

Source files
------------

// File: rtl/stream_mac_accumulator.sv
// Multi-lane streaming multiply-accumulate: sums lane-wise activation x weight products over a
// programmable block length and emits one result beat per block. Block length set via AXI-lite.
module stream_mac_accumulator #(
    parameter int unsigned PE                  = 4,
    parameter int unsigned s_axis_input_WIDTH  = 8,
    parameter bit          s_axis_input_SIGNED = 1'b0,
    parameter int unsigned weights_WIDTH       = 8,
    parameter bit          weights_SIGNED      = 1'b0,
    parameter int unsigned ACC0_WIDTH          = 32,
    parameter int unsigned BDIM_MAX            = 1024,
    parameter int unsigned BDIM_RESET          = 16
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [PE*s_axis_input_WIDTH-1:0] s_axis_input_tdata,
    input  logic                             s_axis_input_tvalid,
    output logic                             s_axis_input_tready,
    input  logic [PE*weights_WIDTH-1:0]      s_axis_weights_tdata,
    input  logic                             s_axis_weights_tvalid,
    output logic                             s_axis_weights_tready,
    output logic [PE*ACC0_WIDTH-1:0]         m_axis_output_tdata,
    output logic                             m_axis_output_tvalid,
    input  logic                             m_axis_output_tready,
    input  logic [3:0]                       s_axilite_config_awaddr,
    input  logic                             s_axilite_config_awvalid,
    output logic                             s_axilite_config_awready,
    input  logic [31:0]                      s_axilite_config_wdata,
    input  logic                             s_axilite_config_wvalid,
    output logic                             s_axilite_config_wready,
    output logic                             s_axilite_config_bvalid,
    input  logic                             s_axilite_config_bready,
    output logic [1:0]                       s_axilite_config_bresp
);
    localparam int unsigned IW   = s_axis_input_WIDTH;
    localparam int unsigned WW   = weights_WIDTH;
    localparam int unsigned AW   = ACC0_WIDTH;
    localparam int unsigned LenW = $clog2(BDIM_MAX + 1);

    typedef enum logic {CfgIdle, CfgResp} cfg_state_e;

    cfg_state_e          cfg_state_q;
    logic [LenW-1:0]     pending_len_q, active_len_q, beat_cnt_q;
    logic [PE*AW-1:0]    acc_q, out_q, acc_nxt;
    logic                out_full_q;
    logic                first_beat, last_beat, core_ready, beat_fire, cfg_accept;
    logic [LenW-1:0]     cur_len, cfg_len;
    logic [AW-1:0]       acc_base;
    logic                unused_addr_bits;

    function automatic logic [AW-1:0] ext_in(input logic [IW-1:0] v);
        return s_axis_input_SIGNED ? {{(AW-IW){v[IW-1]}}, v} : {{(AW-IW){1'b0}}, v};
    endfunction

    function automatic logic [AW-1:0] ext_w(input logic [WW-1:0] v);
        return weights_SIGNED ? {{(AW-WW){v[WW-1]}}, v} : {{(AW-WW){1'b0}}, v};
    endfunction

    assign unused_addr_bits = ^s_axilite_config_awaddr[1:0];

    // A block's first beat uses the pending length; later beats use the latched one.
    always_comb begin
        first_beat = (beat_cnt_q == '0);
        cur_len    = first_beat ? pending_len_q : active_len_q;
        last_beat  = ((beat_cnt_q + LenW'(1)) == cur_len);
        core_ready = !ap_rst && !(last_beat && out_full_q && !m_axis_output_tready);
        beat_fire  = core_ready && s_axis_input_tvalid && s_axis_weights_tvalid;
    end

    always_comb begin
        acc_nxt  = '0;
        acc_base = '0;
        for (int i = 0; i < int'(PE); i++) begin
            acc_base = first_beat ? '0 : acc_q[i*AW +: AW];
            acc_nxt[i*AW +: AW] = acc_base + ext_in(s_axis_input_tdata[i*IW +: IW])
                                           * ext_w(s_axis_weights_tdata[i*WW +: WW]);
        end
    end

    always_comb begin
        if (s_axilite_config_wdata == 32'd0) begin
            cfg_len = LenW'(1);
        end else if (s_axilite_config_wdata > 32'(BDIM_MAX)) begin
            cfg_len = LenW'(BDIM_MAX);
        end else begin
            cfg_len = s_axilite_config_wdata[LenW-1:0];
        end
    end

    assign cfg_accept = !ap_rst && (cfg_state_q == CfgIdle) && s_axilite_config_awvalid &&
                        s_axilite_config_wvalid;

    assign s_axis_input_tready      = core_ready && s_axis_weights_tvalid;
    assign s_axis_weights_tready    = core_ready && s_axis_input_tvalid;
    assign m_axis_output_tvalid     = out_full_q;
    assign m_axis_output_tdata      = out_q;
    assign s_axilite_config_awready = cfg_accept;
    assign s_axilite_config_wready  = cfg_accept;
    assign s_axilite_config_bvalid  = (cfg_state_q == CfgResp);
    assign s_axilite_config_bresp   = 2'b00;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cfg_state_q   <= CfgIdle;
            pending_len_q <= LenW'(BDIM_RESET);
            active_len_q  <= LenW'(BDIM_RESET);
            beat_cnt_q    <= '0;
            acc_q         <= '0;
            out_q         <= '0;
            out_full_q    <= 1'b0;
        end else begin
            if (out_full_q && m_axis_output_tready) begin
                out_full_q <= 1'b0;
            end
            // A final beat landing on the drain cycle wins: full stays set with new data.
            if (beat_fire) begin
                if (first_beat) begin
                    active_len_q <= pending_len_q;
                end
                if (last_beat) begin
                    out_q      <= acc_nxt;
                    out_full_q <= 1'b1;
                    beat_cnt_q <= '0;
                end else begin
                    acc_q      <= acc_nxt;
                    beat_cnt_q <= beat_cnt_q + LenW'(1);
                end
            end
            unique case (cfg_state_q)
                CfgIdle: begin
                    if (cfg_accept) begin
                        if (s_axilite_config_awaddr[3:2] == 2'b00) begin
                            pending_len_q <= cfg_len;
                        end
                        cfg_state_q <= CfgResp;
                    end
                end
                CfgResp: begin
                    if (s_axilite_config_bready) begin
                        cfg_state_q <= CfgIdle;
                    end
                end
                default: cfg_state_q <= CfgIdle;
            endcase
        end
    end

endmodule
